// File: rtl/wb_slave_fifo_regs.sv
// Wishbone classic slave: CTRL / FIFO / STATUS / SCRATCH window over a byte FIFO with level interrupt.
// Define WB_SLV_ERR_EN to add err_o, which terminates push-when-full and pop-when-empty instead of ack_o.
module wb_slave_fifo_regs #(
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
`ifdef WB_SLV_ERR_EN
    output logic                  err_o,
`endif
    output logic                  irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            adr_q, adr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [DATA_WIDTH-1:0] dat_o_q, dat_o_d;
    logic                  ack_q, ack_d;
    logic                  irq_q, irq_d;
    logic [CW-1:0]         ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
`ifdef WB_SLV_ERR_EN
    logic                  err_q, err_d;
`endif

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic                  push_en;
    logic                  empty, full;
    logic [1:0]            sel_adr;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  resp_err;
    logic                  go_resp;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));

    // Response data is captured on the edge that enters ACK, so decode from the live
    // request in IDLE (zero wait states) and from the latched request otherwise.
    assign sel_adr = (state_q == IDLE) ? adr_i[1:0] : adr_q;
    assign sel_we  = (state_q == IDLE) ? we_i : we_q;

    always_comb begin
        rdata = '0;
        case (sel_adr)
            2'd0: rdata[CW-1:0] = ctrl_q;
            2'd1: if (!empty) rdata = fifo_mem[rd_ptr_q];
            2'd2: begin
                rdata[0]      = empty;
                rdata[1]      = full;
                rdata[2]      = ovf_q;
                rdata[3]      = unf_q;
                rdata[CW+3:4] = count_q;
            end
            default: rdata = scratch_q;
        endcase
    end

`ifdef WB_SLV_ERR_EN
    assign resp_err = (sel_adr == 2'd1) && (sel_we ? full : empty);
`else
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        dat_d     = dat_q;
        dat_o_d   = '0;
        ack_d     = 1'b0;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push_en   = 1'b0;
        go_resp   = 1'b0;
`ifdef WB_SLV_ERR_EN
        err_d     = 1'b0;
`endif
        irq_d = ctrl_q[0] && (count_q >= CW'(ctrl_q[CW-1:1])) && (ctrl_q[CW-1:1] != '0);

        case (state_q)
            IDLE: if (cyc_i && stb_i) begin
                adr_d = adr_i[1:0];
                we_d  = we_i;
                dat_d = dat_i;
                cnt_d = WS;
                if (WS == 4'd0) go_resp = 1'b1;
                else            state_d = WAIT;
            end
            WAIT: begin
                if (!cyc_i)             state_d = IDLE;
                else if (cnt_q == 4'd0) go_resp = 1'b1;
                else                    cnt_d = cnt_q - 4'd1;
            end
            ACK: begin
                state_d = HOLD;
                if (we_q) begin
                    case (adr_q)
                        2'd0: ctrl_d = dat_q[CW-1:0];
                        2'd1: if (full) ovf_d = 1'b1;
                              else begin
                                  push_en  = 1'b1;
                                  wr_ptr_d = wr_ptr_q + PW'(1);
                                  count_d  = count_q + CW'(1);
                              end
                        2'd2: begin
                            if (dat_q[2]) ovf_d = 1'b0;
                            if (dat_q[3]) unf_d = 1'b0;
                        end
                        default: scratch_d = dat_q;
                    endcase
                end else if (adr_q == 2'd1) begin
                    if (empty) unf_d = 1'b1;
                    else begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        count_d  = count_q - CW'(1);
                    end
                end
            end
            default: if (!stb_i || !cyc_i) state_d = IDLE;
        endcase

        if (go_resp) begin
            state_d = ACK;
            ack_d   = !resp_err;
            dat_o_d = sel_we ? '0 : rdata;
`ifdef WB_SLV_ERR_EN
            err_d   = resp_err;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) fifo_mem[wr_ptr_q] <= dat_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            dat_q     <= '0;
            dat_o_q   <= '0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
            ctrl_q    <= '0;
            scratch_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
`ifdef WB_SLV_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            dat_q     <= dat_d;
            dat_o_q   <= dat_o_d;
            ack_q     <= ack_d;
            irq_q     <= irq_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
`ifdef WB_SLV_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign dat_o = dat_o_q;
    assign ack_o = ack_q;
    assign irq_o = irq_q;
`ifdef WB_SLV_ERR_EN
    assign err_o = err_q;
`endif
endmodule

// File: tb/tb_wb_slave_fifo_regs.sv
// Directed bench for wb_slave_fifo_regs: read data goes through a scoreboard queue, other checks are inline.
module tb_wb_slave_fifo_regs;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dat_w, dat_o;
    logic       ack, irq, err;
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    wb_slave_fifo_regs dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .cyc_i (cyc),
        .stb_i (stb),
        .we_i  (we),
        .adr_i (adr),
        .dat_i (dat_w),
        .dat_o (dat_o),
        .ack_o (ack),
`ifdef WB_SLV_ERR_EN
        .err_o (err),
`endif
        .irq_o (irq)
    );
`ifndef WB_SLV_ERR_EN
    assign err = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One classic cycle; stb is held for `hold` extra cycles after the termination to probe double acks.
    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d, input int hold,
                           output logic [7:0] rd, output int lat, output logic got_ack, output logic got_err);
        int extra;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        @(posedge clk);
        lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
        while (!got_ack && !got_err && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            got_ack = ack; got_err = err; rd = dat_o;
        end
        check($sformatf("term a%0d w%0d", a, w), 32'(got_ack | got_err), 32'd1);
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            extra += int'(ack | err);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        extra += int'(ack | err);
        check("dat_o_clear", 32'(dat_o), 32'd0);
        check("single_ack", 32'(extra), 32'd0);
        @(posedge clk);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] r; int l; logic ga, ge;
        wb_xfer(1'b1, a, d, 0, r, l, ga, ge);
    endtask

    task automatic wb_read(input logic [1:0] a, input string tag);
        logic [7:0] r, e; int l; logic ga, ge;
        wb_xfer(1'b0, a, 8'h00, 0, r, l, ga, ge);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(r), 32'(e));
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r; int lat; logic ga, ge; int acks;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;

        // Reset
        wait_clks(2);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_dat_o", 32'(dat_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        exp_q.push_back(8'h01);
        wb_read(2'd2, "status_after_reset");

        // SCRATCH with latency and held-strobe single-ack check
        wb_xfer(1'b1, 2'd3, 8'hA5, 4, r, lat, ga, ge);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_ack", 32'(ga), 32'd1);
        exp_q.push_back(8'hA5);
        wb_xfer(1'b0, 2'd3, 8'h00, 3, r, lat, ga, ge);
        check("rd_latency", 32'(lat), 32'd2);
        check("scratch", 32'(r), 32'(exp_q.pop_front()));

        // Fill, overflow, drain, underflow
        for (int i = 0; i < 8; i++) wb_write(2'd1, 8'(8'h11 + i));
        exp_q.push_back(8'h82);
        wb_read(2'd2, "status_full");
        wb_xfer(1'b1, 2'd1, 8'h99, 0, r, lat, ga, ge);
`ifdef WB_SLV_ERR_EN
        check("ovf_err", 32'(ge), 32'd1);
        check("ovf_noack", 32'(ga), 32'd0);
`else
        check("ovf_ack", 32'(ga), 32'd1);
`endif
        exp_q.push_back(8'h86);
        wb_read(2'd2, "status_ovf");
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h11 + i));
            wb_read(2'd1, $sformatf("pop%0d", i));
        end
        exp_q.push_back(8'h00);
        wb_xfer(1'b0, 2'd1, 8'h00, 0, r, lat, ga, ge);
        check("pop_empty_data", 32'(r), 32'(exp_q.pop_front()));
`ifdef WB_SLV_ERR_EN
        check("unf_err", 32'(ge), 32'd1);
        check("unf_noack", 32'(ga), 32'd0);
`else
        check("unf_ack", 32'(ga), 32'd1);
`endif
        exp_q.push_back(8'h0D);
        wb_read(2'd2, "status_unf");

        // W1C then alternating push/pop across pointer wrap
        wb_write(2'd2, 8'h0C);
        exp_q.push_back(8'h01);
        wb_read(2'd2, "status_w1c");
        for (int i = 0; i < 20; i++) begin
            wb_write(2'd1, 8'(8'h30 + i));
            exp_q.push_back(8'(8'h30 + i));
            wb_read(2'd1, $sformatf("wrap%0d", i));
        end

        // Interrupt threshold
        wb_write(2'd0, 8'h07);
        exp_q.push_back(8'h07);
        wb_read(2'd0, "ctrl");
        wb_write(2'd1, 8'hC1);
        wb_write(2'd1, 8'hC2);
        wait_clks(2);
        check("irq_below_thr", 32'(irq), 32'd0);
        wb_write(2'd1, 8'hC3);
        wait_clks(1);
        check("irq_at_thr", 32'(irq), 32'd1);
        exp_q.push_back(8'hC1);
        wb_read(2'd1, "irq_pop");
        wait_clks(1);
        check("irq_after_pop", 32'(irq), 32'd0);

        // Abort during WAIT: no ack, no side effect
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd3; dat_w = 8'h5A;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            acks += int'(ack | err);
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        exp_q.push_back(8'hA5);
        wb_read(2'd3, "scratch_after_abort");
        exp_q.push_back(8'h20);
        wb_read(2'd2, "status_after_abort");

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
